// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   op_e      : instruction encoding on the op port (mult, multu, div, divu)
//   state_e   : controller states
//   iter_cnt_w: width of an iteration counter able to hold 0..width
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  function automatic int unsigned iter_cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned ITER_CNT_W = iter_cnt_w(MULDIV_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiplier / restoring divider.
//   acc      : in  2*WIDTH  multiply: {partial product, remaining multiplier bits}
//                           divide:   {partial remainder, dividend/quotient bits}
//   operand  : in  WIDTH    multiplicand (multiply) or divisor (divide)
//   is_div   : in  1        select the divide step
//   acc_next : out 2*WIDTH  accumulator after this iteration
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_shl;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_shl;

  always_comb begin
    // Multiply: add into the upper half when the multiplier LSB is set, keep the carry,
    // then shift the whole accumulator right by one.
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: remainder < divisor, so the shifted remainder needs one extra bit.
    rem_shl = acc[2*WIDTH-1:WIDTH-1];
    quo_shl = {acc[WIDTH-2:0], 1'b0};
    trial   = rem_shl - {1'b0, operand};

    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_next = {trial[WIDTH-1:0], quo_shl[WIDTH-1:1], 1'b1};
      end else begin
        acc_next = {rem_shl[WIDTH-1:0], quo_shl};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
//   clk, reset        : clock; synchronous active-low reset
//   start, op, a, b   : launch mult/multu/div/divu (accepted only when idle)
//   flush             : abandon an in-flight operation, HI/LO untouched
//   mthi_we, mtlo_we  : write wd into HI / LO while idle
//   hi, lo            : current HI / LO
//   busy              : operation in flight (CALC or FIXUP)
//   done, div_by_zero : one-cycle pulses after a completed operation updates HI/LO
// Operations run on magnitudes; signs are applied once in FIXUP.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  // Never narrower than the package default counter.
  localparam int unsigned CntW =
      (iter_cnt_w(WIDTH) > ITER_CNT_W) ? iter_cnt_w(WIDTH) : ITER_CNT_W;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               psign_q, psign_d;   // product / quotient sign
  logic               rsign_q, rsign_d;   // remainder sign
  logic               zdiv_q, zdiv_d;     // divide by zero in flight
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  op_e                op_in;
  logic               in_signed, in_div, is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_in     = op_e'(op);
  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign a_mag     = (in_signed && a[WIDTH-1]) ? (-a) : a;
  assign b_mag     = (in_signed && b[WIDTH-1]) ? (-b) : b;
  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc_q),
    .operand (opnd_q),
    .is_div  (is_div),
    .acc_next(step_acc)
  );

  // 0x80000000 / -1 needs no special case: magnitude quotient 0x80000000 with a
  // positive sign already reads back as 0x80000000.
  assign prod_fix = psign_q ? (-acc_q) : acc_q;
  assign quo_fix  = psign_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = rsign_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    psign_d = psign_q;
    rsign_d = rsign_q;
    zdiv_d  = zdiv_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (mthi_we) hi_d = wd;
        if (mtlo_we) lo_d = wd;
        if (start && !flush) begin
          op_d    = op_in;
          psign_d = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          rsign_d = in_signed & a[WIDTH-1];
          cnt_d   = '0;
          if (in_div && (b == '0)) begin
            // Keep the raw dividend; it becomes HI unchanged.
            zdiv_d  = 1'b1;
            acc_d   = {{WIDTH{1'b0}}, a};
            state_d = S_FIXUP;
          end else begin
            zdiv_d  = 1'b0;
            acc_d   = {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
            opnd_d  = in_div ? b_mag : a_mag;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (zdiv_q) begin
            hi_d  = acc_q[WIDTH-1:0];
            lo_d  = '1;
            dbz_d = 1'b1;
          end else if (is_div) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      acc_q   <= '0;
      opnd_q  <= '0;
      psign_q <= 1'b0;
      rsign_q <= 1'b0;
      zdiv_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      psign_q <= psign_d;
      rsign_q <= rsign_d;
      zdiv_q  <= zdiv_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, random ops against a
// plain-arithmetic reference, and hand-written flush/reset/mt sequences.
// Latency is the index k of the edge Ek after which done is visible (E0 = launch edge).
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, flush, mthi_we, mtlo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wd, hi, lo;
  logic        busy, done, div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .mthi_we    (mthi_we),
    .mtlo_we    (mtlo_we),
    .wd         (wd),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // done/div_by_zero must never overlap busy; div_by_zero only with done.
  always @(negedge clk) begin
    if (reset && (done || div_by_zero)) begin
      n_checks++;
      if (busy || (div_by_zero && !done)) begin
        n_fail++;
        $display("FAIL pulse_vs_busy: busy=%b done=%b dbz=%b, required busy=0 and dbz only with done",
                 busy, done, div_by_zero);
      end
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit / int arithmetic, MIPS conventions for the corner cases.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl,
                                output logic rdbz);
    logic [63:0] p;
    int sx, sy;
    sx = x;
    sy = y;
    rdbz = 1'b0;
    p = 64'd0;
    rh = 32'd0;
    rl = 32'd0;
    case (o)
      2'b00: begin
        p  = {{32{x[31]}}, x} * {{32{y[31]}}, y};
        rh = p[63:32];
        rl = p[31:0];
      end
      2'b01: begin
        p  = {32'd0, x} * {32'd0, y};
        rh = p[63:32];
        rl = p[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          rh = x; rl = 32'hFFFFFFFF; rdbz = 1'b1;
        end else if (o == 2'b11) begin
          rl = x / y; rh = x % y;
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          rl = 32'h80000000; rh = 32'd0;
        end else begin
          rl = sx / sy; rh = sx % sy;
        end
      end
    endcase
  endfunction

  // Leaves the caller at the negedge following the launch edge (sample 1).
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sample i is taken after edge E(i-1); returns at the negedge where done is seen.
  task automatic wait_done(input int first, output logic [31:0] rh, output logic [31:0] rl,
                           output logic rdbz, output int lat, output int bcyc);
    lat  = -1;
    bcyc = 0;
    rh   = hi;
    rl   = lo;
    rdbz = 1'b0;
    for (int i = first; i <= 80; i++) begin
      if (done) begin
        lat = i - 1; rh = hi; rl = lo; rdbz = div_by_zero;
        break;
      end
      if (busy) bcyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rdbz,
                        output int lat, output int bcyc);
    launch(o, x, y);
    wait_done(1, rh, rl, rdbz, lat, bcyc);
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    mthi_we = h; mtlo_we = l; wd = d;
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b0;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    logic [31:0] rh, rl, eh, el;
    logic        rdbz, edbz;
    int          lat, bcyc, cnt;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3]  = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[5]  = '{2'b01, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 33};
    vecs[6]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
    vecs[7]  = '{2'b10, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1};
    vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 33};
    vecs[11] = '{2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0, 33};

    reset = 1'b0; start = 1'b0; flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wd = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dbz", div_by_zero, 0);
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, rdbz, lat, bcyc);
      check($sformatf("vec%0d_hi", i), rh, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), rl, vecs[i].lo);
      check($sformatf("vec%0d_dbz", i), rdbz, vecs[i].dbz);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), bcyc, vecs[i].lat);
    end

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] x, y;
      int          r;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) y = 32'd0;
      else if (r == 1) y = 32'hFFFFFFFF;
      else if (r == 2) y = $urandom_range(1, 20);
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      model(o, x, y, eh, el, edbz);
      run_op(o, x, y, rh, rl, rdbz, lat, bcyc);
      check($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, o, x, y), rh, eh);
      check($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, o, x, y), rl, el);
      check($sformatf("rnd%0d_dbz", i), rdbz, edbz);
      check($sformatf("rnd%0d_latency", i), lat, edbz ? 1 : 33);
    end

    // mthi in idle, div 50/7, stray start at busy cycle 5, flush at busy cycle 10.
    mt_write(1'b0, 1'b1, 32'h00005555);
    mt_write(1'b1, 1'b0, 32'h00001234);
    check("mthi_idle_hi", hi, 32'h00001234);
    check("mtlo_idle_lo", lo, 32'h00005555);
    launch(2'b10, 32'd50, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      start = (c == 5);
      if (c == 5) begin op = 2'b01; a = 32'd3; b = 32'd3; end
      flush = (c == 10);
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b0;
    check("flush_calc_busy", busy, 0);
    check("flush_calc_hi", hi, 32'h00001234);
    check("flush_calc_lo", lo, 32'h00005555);
    count_done(40, cnt);
    check("flush_calc_no_done", cnt, 0);

    // Start while busy ignored; mt writes while busy ignored.
    mt_write(1'b1, 1'b1, 32'h0BAD0BAD);
    launch(2'b11, 32'd1000, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    mtlo_we = 1'b1; mthi_we = 1'b1; wd = 32'h0000DEAD;
    @(negedge clk);
    start = 1'b0; mtlo_we = 1'b0; mthi_we = 1'b0;
    check("mt_busy_lo", lo, 32'h0BAD0BAD);
    check("mt_busy_hi", hi, 32'h0BAD0BAD);
    wait_done(6, rh, rl, rdbz, lat, bcyc);
    check("busy_start_ignored_lo", rl, 32'd142);
    check("busy_start_ignored_hi", rh, 32'd6);
    check("busy_start_ignored_latency", lat, 33);

    // Flush with start in the same idle cycle suppresses the launch.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 0);
    count_done(40, cnt);
    check("flush_start_no_done", cnt, 0);

    // mthi on the launch edge is applied, then overwritten by the result.
    @(negedge clk);
    mthi_we = 1'b1; wd = 32'hAAAA5555; start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
    @(negedge clk);
    mthi_we = 1'b0; start = 1'b0;
    check("mthi_with_start_hi", hi, 32'hAAAA5555);
    check("mthi_with_start_busy", busy, 1);
    wait_done(1, rh, rl, rdbz, lat, bcyc);
    check("mthi_with_start_res_hi", rh, 32'd0);
    check("mthi_with_start_res_lo", rl, 32'd42);

    // Flush in FIXUP wins over completion.
    mt_write(1'b1, 1'b1, 32'h00000077);
    launch(2'b01, 32'd5, 32'd5);
    repeat (32) @(negedge clk);
    check("fixup_busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_fixup_busy", busy, 0);
    check("flush_fixup_done", done, 0);
    check("flush_fixup_hi", hi, 32'h00000077);
    check("flush_fixup_lo", lo, 32'h00000077);
    count_done(40, cnt);
    check("flush_fixup_no_done", cnt, 0);

    // Reset at busy cycle 20 of a mult.
    mt_write(1'b1, 1'b1, 32'h13579BDF);
    launch(2'b00, 32'h12345678, 32'h9ABCDEF0);
    repeat (19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    reset = 1'b1;
    count_done(40, cnt);
    check("midreset_no_done", cnt, 0);
    run_op(2'b01, 32'd6, 32'd7, rh, rl, rdbz, lat, bcyc);
    check("post_reset_hi", rh, 32'd0);
    check("post_reset_lo", rl, 32'd42);
    check("post_reset_latency", lat, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
